pong_match_ctrl: RTL and testbench
==================================

PONG_MATCH_CTRL -- requirements
Module: pong_match_ctrl

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 7: points needed to win a match, range 1..15.
REQ-002 SHALL have parameter HOLD_FRAMES, default 60: frames the ball stays frozen after a point, range 1..255.
REQ-003 SHALL have parameter AUTO_SERVE_FRAMES, default 180: frames in SERVE before an automatic serve, range 1..255.
REQ-004 SHALL have port clk, input, 1 bit: 100 MHz system clock; all logic runs on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (asserted when 0).
REQ-006 SHALL have port frame_tick, input, 1 bit: one-clk pulse per video frame.
REQ-007 SHALL have port score1, input, 1 bit: level from the ball block; high while the ball is past the right border.
REQ-008 SHALL have port score2, input, 1 bit: level from the ball block; high while the ball is past the left border.
REQ-009 SHALL have port btn_serve, input, 1 bit: asynchronous push-button.
REQ-010 SHALL have port ball_run, output, 1 bit: enables ball motion.
REQ-011 SHALL have port ball_recenter, output, 1 bit: one-clk pulse that tells the ball block to reload its centre position.
REQ-012 SHALL have port serve_dir, output, 1 bit: 0 = serve toward player 1, 1 = serve toward player 2.
REQ-013 SHALL have port p1_points, output, 4 bits: player 1 score.
REQ-014 SHALL have port p2_points, output, 4 bits: player 2 score.
REQ-015 SHALL have port winner, output, 2 bits: 00 none, 01 player 1, 10 player 2.
REQ-016 SHALL have port state_o, output, 3 bits: encoded current state, for debug.

Function
REQ-017 SHALL pass btn_serve through a 2-FF synchroniser and generate a one-clk serve_evt on its synchronised rising edge.
REQ-018 SHALL register score1 and score2 and generate a point event only on a 0->1 transition seen in PLAY, so a held level counts once.
REQ-019 SHALL, when both point events occur in the same clk, award player 1 only.
REQ-020 SHALL implement states IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4; unused encodings SHALL go to IDLE.
REQ-021 SHALL, in IDLE, hold ball_run=0; on serve_evt it SHALL clear both scores, pulse ball_recenter and go to SERVE.
REQ-022 SHALL, on entry to SERVE, load an 8-bit frame counter with AUTO_SERVE_FRAMES, decremented on each frame_tick.
REQ-023 SHALL leave SERVE for PLAY on serve_evt or when the counter reaches 0 at a frame_tick, whichever comes first; ball_run SHALL rise the next clk.
REQ-024 SHALL, in PLAY, hold ball_run=1; on a point event it SHALL increment the scorer's count, set serve_dir toward the player who conceded, drop ball_run, and go to POINT.
REQ-025 SHALL, in POINT, hold for HOLD_FRAMES frame_ticks, then pulse ball_recenter; it SHALL go to OVER if either score equals WIN_SCORE, else to SERVE.
REQ-026 SHALL, in OVER, drive winner to the player at WIN_SCORE, keep ball_run=0, and go to IDLE on serve_evt with winner cleared.
REQ-027 SHALL saturate scores at 15 and never wrap.
REQ-028 SHALL ignore serve_evt in PLAY and POINT.
REQ-029 SHALL assert ball_recenter for exactly one clk per transition and never in two consecutive clks.
REQ-030 SHALL only advance frame counters on frame_tick; frame_tick coinciding with a state change SHALL count toward the new state's counter only if the entry load has already taken effect (the load wins).

Reset
REQ-031 SHALL, while reset=0, asynchronously force: state IDLE, ball_run=0, ball_recenter=0, serve_dir=0, p1_points=0, p2_points=0, winner=00, synchroniser and edge registers 0, counters 0.
REQ-032 SHALL, on reset asserted mid-match, discard all scores; after release it SHALL wait in IDLE for a serve_evt.
REQ-033 SHALL leave the reset release synchronisation to the top level; inside this block the reset SHALL be used as-is.

Verification
REQ-034 Reset release, btn_serve pulse -> state_o 0->1, one ball_recenter pulse, scores 0.
REQ-035 In SERVE, no button, 180 frame_ticks -> PLAY entered on the 180th tick, ball_run=1 next clk.
REQ-036 In PLAY, score1 held high for 5 frames -> p1_points +1 exactly once, serve_dir=1, ball_run=0, 60 ticks later ball_recenter pulse then SERVE.
REQ-037 score1 and score2 rising in the same clk -> only p1_points increments.
REQ-038 p2_points=6, score2 edge (WIN_SCORE=7) -> after the hold, state OVER, winner=10; btn_serve -> IDLE, winner=00.
REQ-039 reset=0 pulsed during POINT with the hold counter at 30 -> all outputs at reset values immediately, no ball_recenter pulse after release.

Source files
------------

// File: rtl/pong_match_ctrl.sv
// Pong match controller: sequences serve, play, point hold and game-over, keeps the
// score and steers the ball block through ball_run / ball_recenter / serve_dir.
module pong_match_ctrl #(
  parameter int unsigned WIN_SCORE         = 7,
  parameter int unsigned HOLD_FRAMES       = 60,
  parameter int unsigned AUTO_SERVE_FRAMES = 180
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       score1,
  input  logic       score2,
  input  logic       btn_serve,
  output logic       ball_run,
  output logic       ball_recenter,
  output logic       serve_dir,
  output logic [3:0] p1_points,
  output logic [3:0] p2_points,
  output logic [1:0] winner,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StServe = 3'd1,
    StPlay  = 3'd2,
    StPoint = 3'd3,
    StOver  = 3'd4
  } state_e;

  localparam logic [3:0] WinScore  = 4'(WIN_SCORE);
  localparam logic [7:0] HoldLoad  = 8'(HOLD_FRAMES);
  localparam logic [7:0] ServeLoad = 8'(AUTO_SERVE_FRAMES);

  state_e     state_q;
  logic [7:0] frame_cnt_q;
  logic       ball_run_q;
  logic       recenter_q;
  logic       serve_dir_q;
  logic [3:0] p1_q;
  logic [3:0] p2_q;
  logic [1:0] winner_q;

  logic btn_meta_q, btn_sync_q, btn_prev_q;
  logic score1_q, score2_q, score1_prev_q, score2_prev_q;

  logic serve_evt;
  logic pt1_evt;
  logic pt2_evt;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // Button synchroniser plus edge register; score levels registered for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_meta_q    <= 1'b0;
      btn_sync_q    <= 1'b0;
      btn_prev_q    <= 1'b0;
      score1_q      <= 1'b0;
      score2_q      <= 1'b0;
      score1_prev_q <= 1'b0;
      score2_prev_q <= 1'b0;
    end else begin
      btn_meta_q    <= btn_serve;
      btn_sync_q    <= btn_meta_q;
      btn_prev_q    <= btn_sync_q;
      score1_q      <= score1;
      score2_q      <= score2;
      score1_prev_q <= score1_q;
      score2_prev_q <= score2_q;
    end
  end

  // Events: a held score level counts once; player 1 wins a simultaneous point
  always_comb begin
    serve_evt = btn_sync_q & ~btn_prev_q;
    pt1_evt   = (state_q == StPlay) & score1_q & ~score1_prev_q;
    pt2_evt   = (state_q == StPlay) & score2_q & ~score2_prev_q & ~pt1_evt;
  end

  // Match FSM with registered outputs; one shared frame counter for serve and hold
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      frame_cnt_q <= 8'd0;
      ball_run_q  <= 1'b0;
      recenter_q  <= 1'b0;
      serve_dir_q <= 1'b0;
      p1_q        <= 4'd0;
      p2_q        <= 4'd0;
      winner_q    <= 2'b00;
    end else begin
      recenter_q <= 1'b0;
      case (state_q)
        StIdle: begin
          ball_run_q <= 1'b0;
          if (serve_evt) begin
            p1_q        <= 4'd0;
            p2_q        <= 4'd0;
            recenter_q  <= 1'b1;
            frame_cnt_q <= ServeLoad;
            state_q     <= StServe;
          end
        end
        StServe: begin
          if (serve_evt || (frame_tick && frame_cnt_q <= 8'd1)) begin
            ball_run_q <= 1'b1;
            state_q    <= StPlay;
          end else if (frame_tick) begin
            frame_cnt_q <= frame_cnt_q - 8'd1;
          end
        end
        StPlay: begin
          if (pt1_evt || pt2_evt) begin
            if (pt1_evt) p1_q <= sat_inc(p1_q);
            else         p2_q <= sat_inc(p2_q);
            // Serve goes toward whoever conceded the point
            serve_dir_q <= pt1_evt;
            ball_run_q  <= 1'b0;
            frame_cnt_q <= HoldLoad;
            state_q     <= StPoint;
          end
        end
        StPoint: begin
          if (frame_tick) begin
            if (frame_cnt_q <= 8'd1) begin
              frame_cnt_q <= 8'd0;
              recenter_q  <= 1'b1;
              if (p1_q == WinScore || p2_q == WinScore) begin
                winner_q <= (p1_q == WinScore) ? 2'b01 : 2'b10;
                state_q  <= StOver;
              end else begin
                frame_cnt_q <= ServeLoad;
                state_q     <= StServe;
              end
            end else begin
              frame_cnt_q <= frame_cnt_q - 8'd1;
            end
          end
        end
        StOver: begin
          ball_run_q <= 1'b0;
          if (serve_evt) begin
            winner_q <= 2'b00;
            state_q  <= StIdle;
          end
        end
        default: begin
          ball_run_q  <= 1'b0;
          frame_cnt_q <= 8'd0;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign ball_run      = ball_run_q;
  assign ball_recenter = recenter_q;
  assign serve_dir     = serve_dir_q;
  assign p1_points     = p1_q;
  assign p2_points     = p2_q;
  assign winner        = winner_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Randomized bench for pong_match_ctrl against a behavioural match model.
module tb_pong_match_ctrl;

  localparam int Win   = 7;
  localparam int Hold  = 60;
  localparam int Auto  = 180;
  localparam int NCyc  = 60000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic       score1 = 1'b0;
  logic       score2 = 1'b0;
  logic       btn_serve = 1'b0;
  logic       ball_run;
  logic       ball_recenter;
  logic       serve_dir;
  logic [3:0] p1_points;
  logic [3:0] p2_points;
  logic [1:0] winner;
  logic [2:0] state_o;

  pong_match_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .frame_tick    (frame_tick),
    .score1        (score1),
    .score2        (score2),
    .btn_serve     (btn_serve),
    .ball_run      (ball_run),
    .ball_recenter (ball_recenter),
    .serve_dir     (serve_dir),
    .p1_points     (p1_points),
    .p2_points     (p2_points),
    .winner        (winner),
    .state_o       (state_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_overs  = 0;
  int n_resets = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
  endtask

  // Behavioural model: mode numbers 0..4 = idle, serve, play, point, over
  int m_mode;
  int m_pts[1:2];
  int m_frames;
  int m_recenter;
  int m_dir;
  int m_win;
  // Input history, index 1 = previous clk edge, 2 = two edges ago, ...
  bit hb[1:3];
  bit hs1[1:2];
  bit hs2[1:2];

  task automatic model_reset();
    m_mode = 0; m_pts[1] = 0; m_pts[2] = 0; m_frames = 0;
    m_recenter = 0; m_dir = 0; m_win = 0;
    hb = '{default: 1'b0}; hs1 = '{default: 1'b0}; hs2 = '{default: 1'b0};
  endtask

  // Advance the model by one rising clock edge with the inputs now applied
  task automatic model_step(input bit b, input bit t, input bit s1, input bit s2);
    bit evt, e1, e2;
    int side;
    evt = hb[2] && !hb[3];
    e1  = hs1[1] && !hs1[2];
    e2  = hs2[1] && !hs2[2];
    m_recenter = 0;
    case (m_mode)
      0: if (evt) begin
        m_pts[1] = 0; m_pts[2] = 0; m_recenter = 1; m_mode = 1; m_frames = Auto;
      end
      1: if (evt) m_mode = 2;
         else if (t) begin
           m_frames--;
           if (m_frames == 0) m_mode = 2;
         end
      2: if (e1 || e2) begin
        side = e1 ? 1 : 2;
        if (m_pts[side] < 15) m_pts[side]++;
        m_dir = (side == 1) ? 1 : 0;
        m_mode = 3;
        m_frames = Hold;
      end
      3: if (t) begin
        m_frames--;
        if (m_frames == 0) begin
          m_recenter = 1;
          if (m_pts[1] == Win || m_pts[2] == Win) begin
            m_mode = 4;
            m_win = (m_pts[1] == Win) ? 1 : 2;
            n_overs++;
          end else begin
            m_mode = 1;
            m_frames = Auto;
          end
        end
      end
      default: if (evt) begin
        m_mode = 0; m_win = 0;
      end
    endcase
    hb[3] = hb[2]; hb[2] = hb[1]; hb[1] = b;
    hs1[2] = hs1[1]; hs1[1] = s1;
    hs2[2] = hs2[1]; hs2[1] = s2;
  endtask

  task automatic compare_all();
    check("state", int'(state_o), m_mode);
    check("ball_run", int'(ball_run), (m_mode == 2) ? 1 : 0);
    check("recenter", int'(ball_recenter), m_recenter);
    check("serve_dir", int'(serve_dir), m_dir);
    check("p1_points", int'(p1_points), m_pts[1]);
    check("p2_points", int'(p2_points), m_pts[2]);
    check("winner", int'(winner), m_win);
  endtask

  task automatic check_reset_values();
    check("rst_state", int'(state_o), 0);
    check("rst_run", int'(ball_run), 0);
    check("rst_recenter", int'(ball_recenter), 0);
    check("rst_dir", int'(serve_dir), 0);
    check("rst_p1", int'(p1_points), 0);
    check("rst_p2", int'(p2_points), 0);
    check("rst_winner", int'(winner), 0);
  endtask

  int btn_left = 0;
  int sc_left  = 0;
  int sc_sel   = 0;

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_reset_values();
    @(negedge clk);
    reset = 1'b1;
    for (int cyc = 0; cyc < NCyc; cyc++) begin
      @(negedge clk);
      compare_all();
      // Asynchronous reset mid-match, favouring the point hold at 30 frames left
      if ($urandom_range(0, 4999) == 0 ||
          (m_mode == 3 && m_frames == 30 && $urandom_range(0, 3) == 0)) begin
        #2 reset = 1'b0;
        #1 check_reset_values();
        model_reset();
        n_resets++;
        repeat (2) @(negedge clk);
        check_reset_values();
        reset = 1'b1;
      end
      if (btn_left == 0 && $urandom_range(0, 299) == 0) btn_left = $urandom_range(3, 10);
      btn_serve = (btn_left != 0);
      if (btn_left != 0) btn_left--;
      if (sc_left == 0 && $urandom_range(0, 39) == 0) begin
        sc_left = $urandom_range(2, 20);
        sc_sel  = $urandom_range(0, 7);
      end
      score1 = (sc_left != 0) && (sc_sel <= 3);
      score2 = (sc_left != 0) && (sc_sel == 0 || sc_sel >= 4);
      if (sc_left != 0) sc_left--;
      frame_tick = 1'($urandom_range(0, 1));
      model_step(btn_serve, frame_tick, score1, score2);
    end
    $display("info: %0d matches completed, %0d mid-run resets", n_overs, n_resets);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
